// File: rtl/rv32im_muldiv_unit.sv
// rtl/rv32im_muldiv_unit.sv - iterative RV32M/RV64M multiply/divide unit with one-entry result cache
// Shared shift register holds {hi, lo} of the product, or {remainder, quotient} while dividing.
module rv32im_muldiv_unit #(
  parameter int XLEN   = 32,
  parameter int UNROLL = 1
) (
  input  logic            clk_i,
  input  logic            reset_ni,
  input  logic            clear_i,
  input  logic [2:0]      operation_i,
  input  logic            data_ready_i,
  input  logic [XLEN-1:0] operand1_i,
  input  logic [XLEN-1:0] operand2_i,
  input  logic            writeback_ce_i,
  output logic [XLEN-1:0] result_o,
  output logic            data_ready_o,
  output logic            busy_o
);

  localparam int N  = XLEN / UNROLL;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [XLEN-1:0] XMIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_e;
  typedef enum logic [2:0] {C_MUU, C_MSS, C_MSU, C_DS, C_DU} cls_e;

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [2:0]          op_q, op_d;
  logic [XLEN-1:0]     op1_q, op1_d, op2_q, op2_d;
  logic [XLEN-1:0]     opa_q, opa_d;
  logic [2*XLEN-1:0]   prod_q, prod_d;
  logic                neg_lo_q, neg_lo_d, neg_hi_q, neg_hi_d;
  cls_e                cls_q, cls_d;
  logic [XLEN-1:0]     res_q, res_d;
  logic                rdy_q, rdy_d;
  logic                c_valid_q, c_valid_d;
  logic [XLEN-1:0]     c_op1_q, c_op1_d, c_op2_q, c_op2_d;
  cls_e                c_cls_q, c_cls_d;
  logic [2*XLEN-1:0]   c_data_q, c_data_d;

  logic                in_div, in_s1, in_s2, sign1, sign2;
  logic [XLEN-1:0]     mag1, mag2;
  cls_e                in_cls;
  logic                hit, div_zero, div_ovf;
  logic [2*XLEN:0]     step_t;
  logic [2*XLEN-1:0]   fix_full, fix_data;
  logic [XLEN-1:0]     fix_q, fix_r, fix_res;

  assign in_div = operation_i[2];
  assign in_s1  = in_div ? !operation_i[0] : (operation_i[1:0] == 2'b01 || operation_i[1:0] == 2'b10);
  assign in_s2  = in_div ? !operation_i[0] : (operation_i[1:0] == 2'b01);
  assign sign1  = in_s1 & operand1_i[XLEN-1];
  assign sign2  = in_s2 & operand2_i[XLEN-1];
  assign mag1   = sign1 ? -operand1_i : operand1_i;
  assign mag2   = sign2 ? -operand2_i : operand2_i;

  always_comb begin
    in_cls = C_MUU;
    case (operation_i)
      3'b001:         in_cls = C_MSS;
      3'b010:         in_cls = C_MSU;
      3'b100, 3'b110: in_cls = C_DS;
      3'b101, 3'b111: in_cls = C_DU;
      default:        in_cls = C_MUU;
    endcase
  end

  // MUL only needs the low product half, which any multiply class provides.
  assign hit = c_valid_q && c_op1_q == operand1_i && c_op2_q == operand2_i &&
               ((operation_i == 3'b000) ? (c_cls_q == C_MUU || c_cls_q == C_MSS || c_cls_q == C_MSU)
                                        : (c_cls_q == in_cls));
  assign div_zero = in_div && operand2_i == '0;
  assign div_ovf  = in_div && !operation_i[0] && operand1_i == XMIN && operand2_i == {XLEN{1'b1}};

  always_comb begin
    step_t = {1'b0, prod_q};
    for (int u = 0; u < UNROLL; u++) begin
      if (op_q[2]) begin
        step_t = step_t << 1;
        if (step_t[2*XLEN:XLEN] >= {1'b0, opa_q}) begin
          step_t[2*XLEN:XLEN] = step_t[2*XLEN:XLEN] - {1'b0, opa_q};
          step_t[0] = 1'b1;
        end
      end else begin
        if (step_t[0]) step_t[2*XLEN:XLEN] = step_t[2*XLEN:XLEN] + {1'b0, opa_q};
        step_t = step_t >> 1;
      end
    end
  end

  assign fix_full = neg_lo_q ? -prod_q : prod_q;
  assign fix_q    = neg_lo_q ? -prod_q[XLEN-1:0] : prod_q[XLEN-1:0];
  assign fix_r    = neg_hi_q ? -prod_q[2*XLEN-1:XLEN] : prod_q[2*XLEN-1:XLEN];
  assign fix_data = op_q[2] ? {fix_r, fix_q} : fix_full;
  assign fix_res  = (op_q[2] ? op_q[1] : (op_q[1:0] != 2'b00)) ? fix_data[2*XLEN-1:XLEN]
                                                               : fix_data[XLEN-1:0];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    op1_d     = op1_q;
    op2_d     = op2_q;
    opa_d     = opa_q;
    prod_d    = prod_q;
    neg_lo_d  = neg_lo_q;
    neg_hi_d  = neg_hi_q;
    cls_d     = cls_q;
    res_d     = res_q;
    rdy_d     = rdy_q;
    c_valid_d = c_valid_q;
    c_op1_d   = c_op1_q;
    c_op2_d   = c_op2_q;
    c_cls_d   = c_cls_q;
    c_data_d  = c_data_q;

    if (writeback_ce_i) rdy_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (data_ready_i) begin
          rdy_d    = 1'b0;
          op_d     = operation_i;
          op1_d    = operand1_i;
          op2_d    = operand2_i;
          opa_d    = in_div ? mag2 : mag1;
          cls_d    = in_cls;
          neg_lo_d = 1'b0;
          neg_hi_d = 1'b0;
          state_d  = S_FIX;
          // Cache and special-case data is already final, so FIX applies no sign fix.
          if (hit) begin
            prod_d = c_data_q;
            cls_d  = c_cls_q;
          end else if (div_zero) begin
            prod_d = {operand1_i, {XLEN{1'b1}}};
          end else if (div_ovf) begin
            prod_d = {{XLEN{1'b0}}, XMIN};
          end else begin
            prod_d   = {{XLEN{1'b0}}, in_div ? mag1 : mag2};
            neg_lo_d = sign1 ^ sign2;
            neg_hi_d = sign1;
            cnt_d    = CW'(N - 1);
            state_d  = S_RUN;
          end
        end
      end
      S_RUN: begin
        prod_d = step_t[2*XLEN-1:0];
        if (cnt_q == '0) state_d = S_FIX;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_FIX: begin
        res_d     = fix_res;
        rdy_d     = 1'b1;
        c_valid_d = 1'b1;
        c_op1_d   = op1_q;
        c_op2_d   = op2_q;
        c_cls_d   = cls_q;
        c_data_d  = fix_data;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (clear_i) begin
      state_d   = S_IDLE;
      rdy_d     = 1'b0;
      res_d     = res_q;
      c_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      op1_q     <= '0;
      op2_q     <= '0;
      opa_q     <= '0;
      prod_q    <= '0;
      neg_lo_q  <= 1'b0;
      neg_hi_q  <= 1'b0;
      cls_q     <= C_MUU;
      res_q     <= '0;
      rdy_q     <= 1'b0;
      c_valid_q <= 1'b0;
      c_op1_q   <= '0;
      c_op2_q   <= '0;
      c_cls_q   <= C_MUU;
      c_data_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      op1_q     <= op1_d;
      op2_q     <= op2_d;
      opa_q     <= opa_d;
      prod_q    <= prod_d;
      neg_lo_q  <= neg_lo_d;
      neg_hi_q  <= neg_hi_d;
      cls_q     <= cls_d;
      res_q     <= res_d;
      rdy_q     <= rdy_d;
      c_valid_q <= c_valid_d;
      c_op1_q   <= c_op1_d;
      c_op2_q   <= c_op2_d;
      c_cls_q   <= c_cls_d;
      c_data_q  <= c_data_d;
    end
  end

  assign result_o     = res_q;
  assign data_ready_o = rdy_q;
  assign busy_o       = (state_q != S_IDLE);

endmodule

// File: tb/tb_rv32im_muldiv_unit.sv
// tb/tb_rv32im_muldiv_unit.sv - randomized self-checking bench for rv32im_muldiv_unit
// Reference results use plain 64-bit arithmetic; a tag model predicts cache-hit latency.
module tb_rv32im_muldiv_unit;

  localparam logic [31:0] MIN = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_n, clear, req1, req4, wb;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic [31:0] res1, res4;
  logic        rdy1, rdy4, busy1, busy4;

  int n_checks = 0;
  int n_fail   = 0;

  bit          m_valid [2];
  logic [31:0] m_a [2];
  logic [31:0] m_b [2];
  int          m_cls [2];
  logic [31:0] last_res;

  always #5 clk = ~clk;

  rv32im_muldiv_unit #(.XLEN(32), .UNROLL(1)) dut1 (
    .clk_i(clk), .reset_ni(rst_n), .clear_i(clear), .operation_i(op),
    .data_ready_i(req1), .operand1_i(a), .operand2_i(b), .writeback_ce_i(wb),
    .result_o(res1), .data_ready_o(rdy1), .busy_o(busy1));

  rv32im_muldiv_unit #(.XLEN(32), .UNROLL(4)) dut4 (
    .clk_i(clk), .reset_ni(rst_n), .clear_i(clear), .operation_i(op),
    .data_ready_i(req4), .operand1_i(a), .operand2_i(b), .writeback_ce_i(wb),
    .result_o(res4), .data_ready_o(rdy4), .busy_o(busy4));

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_res(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] p;
    longint sx, sy;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      3'd0: begin p = {32'b0, x} * {32'b0, y}; return p[31:0]; end
      3'd1: begin p = sx * sy; return p[63:32]; end
      3'd2: begin p = sx * longint'({32'b0, y}); return p[63:32]; end
      3'd3: begin p = {32'b0, x} * {32'b0, y}; return p[63:32]; end
      3'd4: begin
        if (y == 0) return 32'hFFFF_FFFF;
        if (x == MIN && y == 32'hFFFF_FFFF) return MIN;
        p = sx / sy; return p[31:0];
      end
      3'd5: return (y == 0) ? 32'hFFFF_FFFF : x / y;
      3'd6: begin
        if (y == 0) return x;
        if (x == MIN && y == 32'hFFFF_FFFF) return 32'd0;
        p = sx % sy; return p[31:0];
      end
      default: return (y == 0) ? x : x % y;
    endcase
  endfunction

  // 0 MUU, 1 MSS, 2 MSU, 3 DS, 4 DU
  function automatic int cls_of(input logic [2:0] o);
    case (o)
      3'd1: return 1;
      3'd2: return 2;
      3'd4, 3'd6: return 3;
      3'd5, 3'd7: return 4;
      default: return 0;
    endcase
  endfunction

  task automatic invalidate();
    m_valid[0] = 1'b0;
    m_valid[1] = 1'b0;
  endtask

  task automatic run_op(input int sel, input logic [2:0] o, input logic [31:0] x,
                        input logic [31:0] y, input string tag, input bit hold);
    int lat;
    bit hit, special;
    logic [31:0] expv;
    hit = m_valid[sel] && m_a[sel] == x && m_b[sel] == y &&
          ((o == 3'd0) ? (m_cls[sel] <= 2) : (m_cls[sel] == cls_of(o)));
    special = o[2] && (y == 0 || (!o[0] && x == MIN && y == 32'hFFFF_FFFF));
    expv = ref_res(o, x, y);
    @(negedge clk);
    op = o; a = x; b = y;
    if (sel != 0) req4 = 1'b1; else req1 = 1'b1;
    @(posedge clk); #1;
    if (hold) begin
      a = ~x; b = y + 32'd1;
    end else begin
      req1 = 1'b0; req4 = 1'b0;
    end
    check_eq({tag, "_busy"}, (sel != 0) ? busy4 : busy1, 1'b1);
    check_eq({tag, "_rdy0"}, (sel != 0) ? rdy4 : rdy1, 1'b0);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!((sel != 0) ? rdy4 : rdy1) && lat < 200);
    req1 = 1'b0; req4 = 1'b0;
    check_eq({tag, "_lat"}, lat, (hit || special) ? 1 : ((sel != 0) ? 9 : 33));
    check_eq({tag, "_res"}, (sel != 0) ? res4 : res1, expv);
    if (!hit) m_cls[sel] = cls_of(o);
    m_valid[sel] = 1'b1;
    m_a[sel] = x;
    m_b[sel] = y;
    last_res = expv;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0: return 32'd0;
      1: return 32'd1;
      2: return MIN;
      3: return 32'hFFFF_FFFF;
      4: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] rx, ry;
    logic [2:0]  ro;
    rst_n = 1'b0; clear = 1'b0; req1 = 1'b0; req4 = 1'b0; wb = 1'b0;
    op = '0; a = '0; b = '0; last_res = '0;
    invalidate();
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_busy", busy1, 1'b0);
    check_eq("reset_rdy", rdy1, 1'b0);
    check_eq("reset_res", res1, 32'd0);
    @(negedge clk) rst_n = 1'b1;

    run_op(0, 3'd0, 32'd7, 32'hFFFF_FFFD, "mul", 0);
    run_op(1, 3'd0, 32'd7, 32'hFFFF_FFFD, "mul_u4", 0);
    run_op(0, 3'd1, MIN, MIN, "mulh", 0);
    run_op(0, 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu", 0);
    run_op(0, 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhu", 0);
    run_op(0, 3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mul_hit", 0);
    run_op(0, 3'd4, 32'hFFFF_FFF9, 32'd2, "div", 0);
    run_op(0, 3'd6, 32'hFFFF_FFF9, 32'd2, "rem_hit", 0);
    run_op(0, 3'd7, 32'hFFFF_FFF9, 32'd2, "remu", 0);

    @(negedge clk) wb = 1'b1;
    @(posedge clk); #1;
    check_eq("wb_clr", rdy1, 1'b0);
    check_eq("wb_hold_res", res1, last_res);
    wb = 1'b0;

    run_op(0, 3'd5, 32'd5, 32'd0, "divu_z", 0);
    run_op(0, 3'd7, 32'd5, 32'd0, "remu_z", 0);
    run_op(0, 3'd4, MIN, 32'hFFFF_FFFF, "div_ovf", 0);
    run_op(0, 3'd6, MIN, 32'hFFFF_FFFF, "rem_ovf", 0);

    // Flush mid-RUN: result register must keep the previous value.
    @(negedge clk);
    op = 3'd5; a = 32'd1000; b = 32'd7; req1 = 1'b1;
    @(posedge clk); #1 req1 = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk) clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    invalidate();
    check_eq("clr_busy", busy1, 1'b0);
    check_eq("clr_rdy", rdy1, 1'b0);
    check_eq("clr_res", res1, last_res);
    repeat (30) @(posedge clk);
    #1 check_eq("clr_rdy_late", rdy1, 1'b0);
    run_op(0, 3'd5, 32'd1000, 32'd7, "after_clr", 0);

    // Asynchronous reset between edges mid-RUN.
    @(negedge clk);
    op = 3'd0; a = 32'd123; b = 32'd456; req1 = 1'b1;
    @(posedge clk); #1 req1 = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk) rst_n = 1'b0;
    #1;
    check_eq("arst_busy", busy1, 1'b0);
    check_eq("arst_rdy", rdy1, 1'b0);
    check_eq("arst_res", res1, 32'd0);
    #1 rst_n = 1'b1;
    invalidate();
    repeat (40) @(posedge clk);
    #1 check_eq("arst_idle", {busy1, rdy1}, 2'b00);

    run_op(0, 3'd1, 32'h1234_5678, 32'hFEDC_BA98, "hold", 1);
    repeat (3) begin
      @(posedge clk); #1;
      check_eq("hold_busy", busy1, 1'b0);
      check_eq("hold_rdy", rdy1, 1'b1);
      check_eq("hold_res", res1, last_res);
    end

    rx = 32'd3; ry = 32'd5;
    for (int i = 0; i < 90; i++) begin
      if ($urandom_range(0, 2) != 0) begin
        rx = pick();
        ry = pick();
      end
      ro = 3'($urandom_range(0, 7));
      run_op((i < 60) ? 0 : 1, ro, rx, ry, (i < 60) ? "rnd1" : "rnd4", 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rv32im_muldiv_unit.md
# rv32im_muldiv_unit

Parametrised iterative multiply/divide unit implementing the complete RV32M/RV64M operation set (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU) with RISC-V-exact divide-by-zero and overflow results. It sits beside the ALU in the execute stage and uses the same request/busy/data_ready/writeback handshake as the existing multiply/divide block. It generalises that block in three ways: configurable datapath width, configurable bits retired per cycle, and a one-entry result cache so that fused pairs (MULH→MUL, DIV→REM) complete in one cycle.

## Interface
Parameters:
- XLEN, 32: operand and result width; must be 8, 16, 32 or 64.
- UNROLL, 1: bits retired per iteration cycle; must be 1, 2, 4 or 8, and must divide XLEN. N = XLEN/UNROLL.

Ports:
- clk_i  in  1  clock; all state changes on the rising edge.
- reset_ni  in  1  asynchronous, active-low reset.
- clear_i  in  1  synchronous flush, active high.
- operation_i  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- data_ready_i  in  1  request strobe; sampled only while busy_o=0.
- operand1_i  in  XLEN  rs1, dividend.
- operand2_i  in  XLEN  rs2, divisor.
- writeback_ce_i  in  1  consumer has taken the result.
- result_o  out  XLEN  result; holds its value until the next completion.
- data_ready_o  out  1  result_o is valid.
- busy_o  out  1  an operation is in flight.

## Operation
- Reset (reset_ni=0): state IDLE, busy_o=0, data_ready_o=0, result_o=0, cache invalid.
- clear_i (when reset is inactive): state IDLE, busy_o=0, data_ready_o=0, cache invalid. result_o is unchanged. clear_i has priority over every other input.
- Accept: data_ready_i=1 and busy_o=0 at an edge (E0).
  - Latch op, operands and magnitudes.
  - busy_o=1, data_ready_o=0.
- States: IDLE → RUN → FIX → IDLE, or IDLE → FIX directly on a special case or a cache hit.
- RUN: iteration counter loads N-1 at E0, decrements once per edge, and moves to FIX after it reaches 0.
- FIX: apply sign correction, select output, write result_o, set data_ready_o=1, busy_o=0, update cache, return to IDLE.
- Multiply: shift-add of UNROLL bits per cycle into a 2·XLEN product register.
  - Operand signedness: MULH s×s; MULHSU s×u; MULHU and MUL u×u. MUL's low half is signedness-independent.
  - Product is negated when the operand signs differ.
  - MUL returns product[XLEN-1:0]; the MULH variants return product[2XLEN-1:XLEN].
- Divide: restoring division of UNROLL quotient bits per cycle on magnitudes (signed ops) or raw operands (unsigned ops).
  - Quotient is negated when the operand signs differ (signed ops).
  - Remainder takes the sign of the dividend (signed ops).
- Special cases (no RUN state; E0 goes straight to FIX):
  - Divisor = 0: quotient = all ones; remainder = dividend. Applies to signed and unsigned.
  - Signed overflow (dividend = MIN, divisor = -1): quotient = MIN; remainder = 0.
- Result cache:
  - Tag = {op1, op2, class}. Classes: MUU, MSS, MSU, DS, DU.
  - Data = full 2·XLEN product, or quotient and remainder.
  - Entry is written in FIX for every completed operation, including special cases.
  - Hit rules:
    - MUL: operands match and class is any M*.
    - MULH, MULHSU, MULHU: exact class match.
    - DIV/REM: class DS. DIVU/REMU: class DU.
  - On a hit, E0 → FIX; no RUN cycles.
- data_ready_o clears on writeback_ce_i or on a new accept. If both coincide with a FIX completion, FIX wins (data_ready_o=1).
- data_ready_i while busy_o=1 is ignored; the request is not queued.

## Timing
- Normal operation:
  - Accept at E0; RUN occupies edges E1..EN; FIX at EN+1.
  - data_ready_o and result_o are valid after EN+1: N+1 edges after accept, so busy_o is high for N+1 cycles.
- Special case or cache hit: result valid after E1; busy_o is high for 1 cycle.
- Back-to-back: a new accept is permitted in the cycle after FIX (busy_o=0, data_ready_o=1). That accept clears data_ready_o.
- Reset asserted mid-operation: outputs reach their reset values immediately (asynchronously), with no clock edge required.

## Test plan
Bench settings: XLEN=32, UNROLL=1, so N=32.
- MUL 7 × 0xFFFFFFFD → result_o 0xFFFFFFEB. data_ready_o rises exactly 33 edges after accept. Repeat with UNROLL=4 → 9 edges.
- MULH 0x80000000×0x80000000 → 0x40000000. MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF. MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE. Then MUL with the same operands → 0x00000001 in 1 edge (cache hit).
- DIV 0xFFFFFFF9/2 → 0xFFFFFFFD. Then REM with the same operands → 0xFFFFFFFF in 1 edge (hit). Then REMU with the same operands → full latency, result 0x00000001.
- DIVU 5/0 → 0xFFFFFFFF; REMU 5/0 → 5; DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM of the same → 0. Each completes 1 edge after accept.
- Assert clear_i on RUN cycle 10 → busy_o=0 next edge, data_ready_o stays 0. Then repeat an identical op → full latency (cache was invalidated), correct result.
- Pulse reset_ni low between edges mid-RUN → busy_o, data_ready_o, result_o = 0 before the next edge. Hold data_ready_i while busy_o=1 → the extra request is not executed.
